// File: rtl/lb_pkg.sv
// Shared definitions for the lb_tx_timer bit-period timer: FSM encoding and width defaults.
package lb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } lb_state_e;

    localparam int LB_DIV_W = 16;
    localparam int LB_BIT_W = 4;

endpackage

// File: rtl/lb_mod_counter.sv
// Up-counter with synchronous clear and wrap at a programmable terminal value.
module lb_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;

    assign wrap  = inc && (count_q == terminal);
    assign count = count_q;

    // clear wins over inc so an abort on a terminal cycle still lands on zero
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lb_tx_timer.sv
// Bit-period timer for a serial transmitter: times nbits periods of divisor clocks each.
//
//   state  | meaning
//   IDLE   | waiting for start; counters held at zero
//   RUN    | timing bit periods, busy=1
//   FINISH | single done cycle, bit_idx shows the frame length
module lb_tx_timer
    import lb_pkg::*;
#(
    parameter int DIV_W = LB_DIV_W,
    parameter int BIT_W = LB_BIT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] divisor,
    input  logic [BIT_W-1:0] nbits,
    output logic             bit_tick,
    output logic [BIT_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    lb_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] nbits_q, nbits_d;

    logic [DIV_W-1:0] baud_cnt;
    logic             baud_wrap;
    logic [BIT_W-1:0] bit_cnt;
    logic             bit_wrap;
    logic             in_run;
    logic             cnt_clear;
    logic             tick;

    assign in_run    = (state_q == RUN);
    assign cnt_clear = !in_run || abort;
    assign tick      = baud_wrap && (nbits_q != '0);

    lb_mod_counter #(.WIDTH(DIV_W)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (in_run),
        .terminal (div_q - DIV_W'(1)),
        .count    (baud_cnt),
        .wrap     (baud_wrap)
    );

    // wraps on the last bit period, which doubles as the end-of-frame strobe
    lb_mod_counter #(.WIDTH(BIT_W)) u_bits (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (tick),
        .terminal (nbits_q - BIT_W'(1)),
        .count    (bit_cnt),
        .wrap     (bit_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            nbits_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            nbits_q <= nbits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        nbits_d = nbits_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    div_d   = (divisor == '0) ? DIV_W'(1) : divisor;
                    nbits_d = nbits;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (nbits_q == '0 || bit_wrap) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // the bit counter has already wrapped to zero by FINISH, so show the latched length there
    assign bit_tick = tick;
    assign busy     = in_run;
    assign done     = (state_q == FINISH);
    assign bit_idx  = done ? nbits_q : bit_cnt;

endmodule

// File: tb/tb_lb_tx_timer.sv
// Scoreboard bench for lb_tx_timer: a frame-timing model pushes expected outputs per cycle.
module tb_lb_tx_timer;

    localparam int DW = 4;
    localparam int BW = 4;

    typedef struct {
        logic          tick;
        logic [BW-1:0] idx;
        logic          busy;
        logic          done;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [DW-1:0] divisor;
    logic [BW-1:0] nbits;
    logic          bit_tick, busy, done;
    logic [BW-1:0] bit_idx;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc_no = 0;

    bit m_act = 1'b0;
    int m_t   = 0;
    int m_d   = 1;
    int m_n   = 0;

    always #5 clk = ~clk;

    lb_tx_timer #(.DIV_W(DW), .BIT_W(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .divisor  (divisor),
        .nbits    (nbits),
        .bit_tick (bit_tick),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .done     (done)
    );

    function automatic int run_len();
        return (m_n == 0) ? 1 : m_n * m_d;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc_no, got, exp);
        end
    endtask

    // one clock: apply inputs for the coming edge, predict, then check the following cycle
    task automatic cyc(input logic r, input logic s, input logic a, input int dv, input int nb);
        exp_t e;
        exp_t g;
        int   rl;
        reset   = r;
        start   = s;
        abort   = a;
        divisor = dv[DW-1:0];
        nbits   = nb[BW-1:0];

        if (r) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (a && m_t <= run_len()) begin
                m_act = 1'b0;
            end else begin
                m_t++;
                if (m_t > run_len() + 1) m_act = 1'b0;
            end
        end else if (s && !a) begin
            m_act = 1'b1;
            m_t   = 1;
            m_d   = (dv == 0) ? 1 : dv;
            m_n   = nb;
        end

        e.tick = 1'b0;
        e.idx  = '0;
        e.busy = 1'b0;
        e.done = 1'b0;
        if (m_act) begin
            rl     = run_len();
            e.busy = (m_t <= rl);
            e.done = (m_t == rl + 1);
            e.tick = (m_n != 0) && (m_t <= rl) && (m_t % m_d == 0);
            e.idx  = e.done ? m_n[BW-1:0] : BW'((m_t - 1) / m_d);
        end
        sb.push_back(e);

        @(posedge clk);
        @(negedge clk);
        cyc_no++;

        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard cycle %0d: got empty queue, expected an entry", cyc_no);
        end else begin
            g = sb.pop_front();
            chk("bit_tick", int'(bit_tick), int'(g.tick));
            chk("bit_idx",  int'(bit_idx),  int'(g.idx));
            chk("busy",     int'(busy),     int'(g.busy));
            chk("done",     int'(done),     int'(g.done));
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, $urandom_range(15), $urandom_range(15));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        divisor = '0;
        nbits   = '0;
        @(negedge clk);

        // reset, including reset overriding start and abort
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 3, 2);
        cyc(1'b1, 1'b1, 1'b1, 3, 2);
        idle(2);

        // nominal frame div=4 nbits=3
        cyc(1'b0, 1'b1, 1'b0, 4, 3);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 4, 3);
        idle(1);

        // divisor 0 treated as 1, then zero-length frame
        cyc(1'b0, 1'b1, 1'b0, 0, 2);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 2);
        cyc(1'b0, 1'b1, 1'b0, 3, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 3, 0);

        // abort in cycle 7 of div=5 nbits=4
        cyc(1'b0, 1'b1, 1'b0, 5, 4);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 5, 4);
        cyc(1'b0, 1'b0, 1'b1, 5, 4);
        idle(3);

        // start re-pulse and divisor change during a div=4 nbits=2 frame
        cyc(1'b0, 1'b1, 1'b0, 4, 2);
        cyc(1'b0, 1'b0, 1'b0, 4, 2);
        cyc(1'b0, 1'b1, 1'b0, 9, 2);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 9, 2);

        // reset in cycle 6, then a clean frame
        cyc(1'b0, 1'b1, 1'b0, 4, 3);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 4, 3);
        cyc(1'b1, 1'b0, 1'b0, 4, 3);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 4, 3);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 4, 3);

        // start with abort in IDLE is blocked
        cyc(1'b0, 1'b1, 1'b1, 4, 3);
        cyc(1'b0, 1'b1, 1'b1, 4, 3);
        idle(1);

        // maximum divisor for a 4-bit divider
        cyc(1'b0, 1'b1, 1'b0, 15, 1);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 15, 1);

        // divisor 1 ticks every RUN cycle; abort held through FINISH is ignored
        cyc(1'b0, 1'b1, 1'b0, 1, 3);
        cyc(1'b0, 1'b0, 1'b0, 1, 3);
        cyc(1'b0, 1'b0, 1'b0, 1, 3);
        cyc(1'b0, 1'b0, 1'b1, 1, 3);
        cyc(1'b0, 1'b0, 1'b0, 1, 3);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 2, 1);
        cyc(1'b0, 1'b0, 1'b0, 2, 1);
        cyc(1'b0, 1'b0, 1'b0, 2, 1);
        cyc(1'b0, 1'b0, 1'b1, 2, 1);
        idle(2);

        // start held continuously: FINISH ignores it, the next IDLE cycle accepts it
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 2, 2);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lb_tx_timer.md
LB_TX_TIMER -- requirements
Module: lb_tx_timer

Interface
REQ-001 Parameter DIV_W, default 16, width of the baud divisor and baud counter.
REQ-002 Parameter BIT_W, default 4, width of the bit-count input and bit index.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a timed frame; sampled only in IDLE.
REQ-006 abort  input  1  terminates a running frame without done.
REQ-007 divisor  input  DIV_W  clock cycles per bit period; 0 treated as 1.
REQ-008 nbits  input  BIT_W  number of bit periods per frame.
REQ-009 bit_tick  output  1  one-cycle pulse at the end of each bit period.
REQ-010 bit_idx  output  BIT_W  count of completed bit periods in the current frame.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse after the last bit period of a non-aborted frame.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, FINISH.
REQ-014 IDLE->RUN SHALL occur on the edge where start=1 and abort=0. The same edge latches divisor (0 mapped to 1) and nbits, and clears the baud counter and bit_idx to 0.
REQ-015 divisor and nbits changes while in RUN or FINISH SHALL have no effect on the current frame.
REQ-016 start while in RUN or FINISH SHALL be ignored. It is neither queued nor able to restart the frame.
REQ-017 In RUN, the baud counter SHALL increment every cycle from 0 to latched_div-1, then wrap to 0.
REQ-018 bit_tick SHALL be high, combinationally from registered state, exactly in RUN cycles where baud counter = latched_div-1.
REQ-019 On each bit_tick edge, bit_idx SHALL increment by 1. bit_idx never wraps.
REQ-020 RUN->FINISH SHALL occur on the bit_tick edge where bit_idx reaches latched_nbits.
REQ-021 If latched_nbits=0, RUN->FINISH SHALL occur on the first RUN edge, with no bit_tick.
REQ-022 Timing for a start accepted at edge k:
- busy is high in cycles k+1 .. k+nbits*div.
- Bit ticks occur in cycles k+div, k+2*div, ..., k+nbits*div.
- done is high in cycle k+nbits*div+1 (FINISH).
- The FSM is in IDLE from cycle k+nbits*div+2.
REQ-023 FINISH SHALL last exactly one cycle, with done=1 and busy=0, and SHALL return to IDLE unconditionally.
REQ-024 bit_idx SHALL hold latched_nbits in FINISH and clear to 0 on FINISH->IDLE.
REQ-025 abort=1 in RUN SHALL return the FSM to IDLE on that edge, clear both counters, and suppress bit_tick in that cycle. No done SHALL follow.
REQ-026 abort in IDLE SHALL block start; abort in FINISH SHALL be ignored and done still completes.
REQ-027 divisor=1 SHALL produce bit_tick on every RUN cycle.
REQ-028 Counter arithmetic SHALL be unsigned and width-exact. A maximum divisor of 2^DIV_W-1 SHALL work without overflow.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, clear the baud counter and bit_idx, and clear the latched divisor and nbits.
REQ-030 During and after reset, busy=0, done=0, bit_tick=0 and bit_idx=0 SHALL hold; reset overrides start and abort.
REQ-031 Reset asserted mid-frame SHALL terminate the frame with no done pulse.

Structure
REQ-032 The state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2) and the DIV_W/BIT_W defaults SHALL live in the shared lb_pkg include.
REQ-033 A sub-module lb_mod_counter SHALL be used, instantiated twice: once for the baud divider and once for the bit counter.
- Parameter: WIDTH.
- Inputs: clk, reset, clear, inc, terminal.
- Outputs: count, wrap (combinational pulse when inc and count=terminal).
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no input-to-output combinational paths.

Verification
REQ-035 Nominal frame: divisor=4, nbits=3, start at edge 0 -> bit_tick in cycles 4, 8, 12; bit_idx steps 1, 2, 3; done in cycle 13; busy cycles 1..12.
REQ-036 Zero and unit values: divisor=0, nbits=2 -> ticks in cycles 1, 2 and done in cycle 3. nbits=0 -> no tick, done in cycle 2.
REQ-037 Abort mid-frame: divisor=5, nbits=4, abort in cycle 7 -> single tick at cycle 5, no done, IDLE with bit_idx=0 at cycle 8.
REQ-038 Ignored inputs: start re-pulsed at cycle 3 and divisor changed to 9 at cycle 3 during a divisor=4, nbits=2 frame -> ticks remain at cycles 4 and 8, done at cycle 9, one frame only.
REQ-039 Reset mid-frame: reset in cycle 6 of a divisor=4, nbits=3 frame -> all outputs 0 from cycle 7 and no done. A start after reset runs a clean frame.
REQ-040 Simultaneous inputs in IDLE: start=1 and abort=1 together -> stays IDLE with busy=0. Maximum divisor with DIV_W=4 (divisor=15), nbits=1 -> tick at cycle 15, done at cycle 16.
